// File: rtl/instruction_memory.sv
// instruction_memory: word-organised fetch memory with a
// byte-serial big-endian program loader, stall and flush.
module instruction_memory #(
  parameter int NBITS = 32,
  parameter int NWORDS = 256,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF,
  localparam int AW = $clog2(NWORDS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_en,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  input  logic [NBITS-1:0] i_pc,
  input  logic             i_fetch_en,
  input  logic             i_flush,
  output logic [NBITS-1:0] o_instruction,
  output logic             o_halt,
  output logic             o_load_done,
  output logic             o_load_error,
  output logic [AW:0]      o_words_loaded
);

  logic [NBITS-1:0] mem [NWORDS];

  logic [1:0]       byte_cnt;
  logic [NBITS-9:0] asm_q;
  logic [AW-1:0]    wr_ptr;

  logic             accept;
  logic             last_byte;
  logic             we;
  logic [NBITS-1:0] wr_word;
  logic [AW-1:0]    rd_idx;
  logic [NBITS-1:0] rd_word;
  logic             unused_pc;

  // Only the first three bytes are held; the fourth
  // completes the word straight from the input.
  assign accept    = i_load_en & i_byte_valid & ~o_load_done;
  assign last_byte = accept & (byte_cnt == 2'd3);
  assign we        = last_byte & ~i_rst;
  assign wr_word   = {asm_q, i_byte};

  assign rd_idx    = i_pc[AW+1:2];
  assign rd_word   = mem[rd_idx];
  assign unused_pc = ^{i_pc[NBITS-1:AW+2], i_pc[1:0]};

  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_cnt       <= '0;
      asm_q          <= '0;
      wr_ptr         <= '0;
      o_instruction  <= '0;
      o_halt         <= 1'b0;
      o_load_done    <= 1'b0;
      o_load_error   <= 1'b0;
      o_words_loaded <= '0;
    end else if (i_load_en) begin
      o_instruction <= '0;
      o_halt        <= 1'b0;
      if (i_byte_valid && o_load_done) begin
        o_load_error <= 1'b1;
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_q    <= {asm_q[NBITS-17:0], i_byte};
      end
      if (last_byte) begin
        wr_ptr         <= wr_ptr + 1'b1;
        o_words_loaded <= o_words_loaded + 1'b1;
        if (wr_word == HALT_WORD || &wr_ptr) begin
          o_load_done <= 1'b1;
        end
      end
    end else if (i_flush) begin
      o_instruction <= '0;
      o_halt        <= 1'b0;
    end else if (i_fetch_en) begin
      o_instruction <= rd_word;
      o_halt        <= (rd_word == HALT_WORD);
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: directed loads,
// fetches, stalls, flushes, wrap and reset cases.
module tb_instruction_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, le, bv, fe, fl;
  logic [7:0]  bt;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        halt, done, err;
  logic [8:0]  wl;

  logic        rst4, le4, bv4, fe4, fl4;
  logic [7:0]  bt4;
  logic [31:0] pc4;
  logic [31:0] ins4;
  logic        halt4, done4, err4;
  logic [2:0]  wl4;

  instruction_memory dut (
    .i_clk(clk), .i_rst(rst), .i_load_en(le),
    .i_byte_valid(bv), .i_byte(bt), .i_pc(pc),
    .i_fetch_en(fe), .i_flush(fl),
    .o_instruction(ins), .o_halt(halt),
    .o_load_done(done), .o_load_error(err),
    .o_words_loaded(wl)
  );

  instruction_memory #(.NWORDS(4)) dut4 (
    .i_clk(clk), .i_rst(rst4), .i_load_en(le4),
    .i_byte_valid(bv4), .i_byte(bt4), .i_pc(pc4),
    .i_fetch_en(fe4), .i_flush(fl4),
    .o_instruction(ins4), .o_halt(halt4),
    .o_load_done(done4), .o_load_error(err4),
    .o_words_loaded(wl4)
  );

  typedef struct {
    string       name;
    bit          sel4;
    bit          ck_ins;
    logic [31:0] ins;
    bit          halt;
    bit          ck_ld;
    logic [8:0]  words;
    bit          done;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.ck_ins) begin
        chk({e.name, ".ins"}, e.sel4 ? ins4 : ins, e.ins);
        chk({e.name, ".halt"}, 32'(e.sel4 ? halt4 : halt),
            32'(e.halt));
      end
      if (e.ck_ld) begin
        chk({e.name, ".words"},
            32'(e.sel4 ? {6'b0, wl4} : wl), 32'(e.words));
        chk({e.name, ".done"}, 32'(e.sel4 ? done4 : done),
            32'(e.done));
        chk({e.name, ".err"}, 32'(e.sel4 ? err4 : err),
            32'(e.err));
      end
    end
  end

  task automatic push_ins(input string n, input bit s4,
                          input logic [31:0] x, input bit h);
    exp_t t;
    t = '{name: n, sel4: s4, ck_ins: 1'b1, ins: x, halt: h,
          ck_ld: 1'b0, words: '0, done: 1'b0, err: 1'b0,
          cyc: cyc + 1};
    sbq.push_back(t);
  endtask

  task automatic push_ld(input string n, input bit s4,
                         input logic [8:0] w, input bit d,
                         input bit er);
    exp_t t;
    t = '{name: n, sel4: s4, ck_ins: 1'b0, ins: '0, halt: 1'b0,
          ck_ld: 1'b1, words: w, done: d, err: er,
          cyc: cyc + 1};
    sbq.push_back(t);
  endtask

  task automatic drive(input bit s4, input bit r, input bit l,
                       input bit v, input logic [7:0] b,
                       input logic [31:0] p, input bit f,
                       input bit fls);
    @(negedge clk);
    if (s4) begin
      rst4 = r; le4 = l; bv4 = v; bt4 = b;
      pc4 = p; fe4 = f; fl4 = fls;
    end else begin
      rst = r; le = l; bv = v; bt = b;
      pc = p; fe = f; fl = fls;
    end
  endtask

  task automatic load_byte(input bit s4, input logic [7:0] b);
    drive(s4, 1'b0, 1'b1, 1'b1, b, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic fetch(input bit s4, input logic [31:0] p);
    drive(s4, 1'b0, 1'b0, 1'b0, 8'h00, p, 1'b1, 1'b0);
  endtask

  task automatic stall(input bit s4, input logic [31:0] p);
    drive(s4, 1'b0, 1'b0, 1'b0, 8'h00, p, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  logic [7:0] prog [12];
  logic [7:0] prog4 [16];

  initial begin
    prog = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00,
             8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 16; i++) prog4[i] = 8'(i + 1);
    rst = 1'b1; le = 1'b0; bv = 1'b0; bt = '0;
    pc = '0; fe = 1'b0; fl = 1'b0;
    rst4 = 1'b1; le4 = 1'b0; bv4 = 1'b0; bt4 = '0;
    pc4 = '0; fe4 = 1'b0; fl4 = 1'b0;

    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
    push_ins("reset", 1'b0, 32'h0, 1'b0);
    push_ld("reset", 1'b0, 9'd0, 1'b0, 1'b0);
    push_ins("reset4", 1'b1, 32'h0, 1'b0);
    push_ld("reset4", 1'b1, 9'd0, 1'b0, 1'b0);
    stall(1'b1, 32'h0);

    for (int i = 0; i < 12; i++) begin
      load_byte(1'b0, prog[i]);
      if (i == 0) push_ins("load_out", 1'b0, 32'h0, 1'b0);
      if (i == 3) push_ld("word1", 1'b0, 9'd1, 1'b0, 1'b0);
      if (i == 11) push_ld("halt_done", 1'b0, 9'd3, 1'b1, 1'b0);
    end
    load_byte(1'b0, 8'h12);
    push_ld("late_byte", 1'b0, 9'd3, 1'b1, 1'b1);

    fetch(1'b0, 32'h0);
    push_ins("fetch0", 1'b0, 32'h8C01_0004, 1'b0);
    fetch(1'b0, 32'h4);
    push_ins("fetch4", 1'b0, 32'h0, 1'b0);
    fetch(1'b0, 32'h8);
    push_ins("fetch8", 1'b0, 32'hFFFF_FFFF, 1'b1);

    fetch(1'b0, 32'h4);
    push_ins("pre_stall", 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stall(1'b0, 32'h8);
      push_ins("stall_w1", 1'b0, 32'h0, 1'b0);
    end
    fetch(1'b0, 32'h0);
    push_ins("pre_stall0", 1'b0, 32'h8C01_0004, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stall(1'b0, 32'h8);
      push_ins("stall_w0", 1'b0, 32'h8C01_0004, 1'b0);
    end
    fetch(1'b0, 32'h8);
    push_ins("unstall", 1'b0, 32'hFFFF_FFFF, 1'b1);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b1);
    push_ins("flush", 1'b0, 32'h0, 1'b0);
    fetch(1'b0, 32'h0);
    push_ins("post_flush", 1'b0, 32'h8C01_0004, 1'b0);
    fetch(1'b0, 32'hB);
    push_ins("unaligned", 1'b0, 32'hFFFF_FFFF, 1'b1);
    fetch(1'b0, 32'h401);
    push_ins("wrap256", 1'b0, 32'h8C01_0004, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hAB, 32'h4, 1'b1, 1'b0);
    push_ins("run_byte", 1'b0, 32'h0, 1'b0);
    push_ld("run_byte", 1'b0, 9'd3, 1'b1, 1'b1);

    load_byte(1'b0, 8'hAA);
    load_byte(1'b0, 8'hBB);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hCC, 32'h0, 1'b0, 1'b0);
    push_ins("mid_rst", 1'b0, 32'h0, 1'b0);
    push_ld("mid_rst", 1'b0, 9'd0, 1'b0, 1'b0);
    load_byte(1'b0, 8'h11);
    load_byte(1'b0, 8'h22);
    load_byte(1'b0, 8'h33);
    load_byte(1'b0, 8'h44);
    push_ld("reload_w0", 1'b0, 9'd1, 1'b0, 1'b0);
    load_byte(1'b0, 8'h55);
    load_byte(1'b0, 8'h66);
    for (int i = 0; i < 5; i++) stall(1'b0, 32'h0);
    push_ld("paused", 1'b0, 9'd1, 1'b0, 1'b0);
    load_byte(1'b0, 8'h77);
    load_byte(1'b0, 8'h88);
    push_ld("resumed", 1'b0, 9'd2, 1'b0, 1'b0);
    fetch(1'b0, 32'h0);
    push_ins("rd_w0", 1'b0, 32'h1122_3344, 1'b0);
    fetch(1'b0, 32'h4);
    push_ins("rd_w1", 1'b0, 32'h5566_7788, 1'b0);
    fetch(1'b0, 32'h8);
    push_ins("mem_kept", 1'b0, 32'hFFFF_FFFF, 1'b1);

    for (int i = 0; i < 16; i++) begin
      load_byte(1'b1, prog4[i]);
      if (i == 11) push_ld("n4_w3", 1'b1, 9'd3, 1'b0, 1'b0);
      if (i == 15) push_ld("n4_full", 1'b1, 9'd4, 1'b1, 1'b0);
    end
    fetch(1'b1, 32'h10);
    push_ins("n4_wrap", 1'b1, 32'h0102_0304, 1'b0);
    fetch(1'b1, 32'hC);
    push_ins("n4_w3rd", 1'b1, 32'h0D0E_0F10, 1'b0);
    fetch(1'b1, 32'h15);
    push_ins("n4_wrap1", 1'b1, 32'h0506_0708, 1'b0);
    load_byte(1'b1, 8'h99);
    push_ld("n4_late", 1'b1, 9'd4, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
# instruction_memory

Word-organised instruction memory for the fetch stage, directly downstream of the program counter: it takes the byte address held in the PC register and returns the addressed instruction one cycle later, registered for the IF/ID boundary. Before execution, the debug unit loads the program through a byte-serial port. The loader packs bytes into 32-bit words, writes them sequentially from word 0, and stops at the HALT word or when memory is full. In run mode the block also supports stall (hold) and flush (NOP injection).

## Interface
- NBITS, 32, width of the PC byte address and of the instruction word
- NWORDS, 256, memory depth in words; must be a power of two; AW = clog2(NWORDS)
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that terminates loading and flags HALT in run mode
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_load_en  input  1  1 = load mode (debug unit writes), 0 = run mode (fetch reads)
- i_byte_valid  input  1  i_byte is valid this cycle; only honoured in load mode
- i_byte  input  8  program byte, big-endian: first byte of a word goes to bits [31:24]
- i_pc  input  NBITS  byte address from the PC register; word index = i_pc[AW+1:2], bits [1:0] ignored
- i_fetch_en  input  1  0 = stall; o_instruction and o_halt hold
- i_flush  input  1  inject NOP (32'h0) on the next edge; priority over i_fetch_en
- o_instruction  output  NBITS  registered fetched instruction
- o_halt  output  1  registered; 1 when o_instruction == HALT_WORD
- o_load_done  output  1  sticky; program complete (HALT word written or memory full)
- o_load_error  output  1  sticky; a byte arrived while o_load_done = 1
- o_words_loaded  output  AW+1  count of words written since reset

## Operation
- Reset values:
  - Byte counter 0, assembly register 0, write pointer 0.
  - o_instruction 0, o_halt 0, o_load_done 0, o_load_error 0, o_words_loaded 0.
  - Memory array is not cleared by reset (power-up contents are 0). A new load overwrites from word 0.
- Load mode (i_load_en = 1):
  - Each accepted byte (i_byte_valid & !o_load_done) shifts into the assembly register, MSB-first. The byte counter increments mod 4.
  - On the 4th byte, the assembled word {b0,b1,b2,b3} is written to mem[wr_ptr]. wr_ptr and o_words_loaded increment on the same edge.
  - If the written word == HALT_WORD, or wr_ptr == NWORDS-1, o_load_done sets on that edge.
  - A valid byte while o_load_done = 1 is dropped, and o_load_error sets.
  - i_byte_valid low: no state change. Dropping i_load_en mid-word keeps the partial word and byte count; loading resumes when i_load_en returns.
  - o_instruction is driven to 0 and o_halt to 0 every edge while i_load_en = 1.
- Run mode (i_load_en = 0); priority per edge, highest first:
  - i_flush = 1: o_instruction <= 0, o_halt <= 0.
  - i_fetch_en = 1: o_instruction <= mem[i_pc[AW+1:2]], o_halt <= (that word == HALT_WORD).
  - Otherwise: hold both outputs.
  - i_byte_valid is ignored in run mode.
- Addressing:
  - i_pc beyond NWORDS*4 wraps, by truncation to AW index bits.
  - Unaligned i_pc reads the containing word.
- Reads and writes never occur on the same edge (the two modes are exclusive), so read-during-write has no defined case.

## Timing
- Read latency: 1 cycle. i_pc sampled at edge k gives o_instruction valid after edge k, aligned with the PC register's update at the same edge.
- Flush latency: 1 cycle. Stall holds the output for exactly as many cycles as i_fetch_en is low.
- Load: the 4th byte accepted at edge k writes the memory at edge k. The updated o_words_loaded and o_load_done are visible after edge k, and a read of that word is possible from edge k+1 onward in run mode.
- Back-to-back bytes are accepted every cycle; there is no backpressure.
- i_rst asserted mid-word or mid-run: all registers return to their reset values on that edge. Memory contents remain intact.

## Test plan
- Load bytes 8C,01,00,04, 00,00,00,00, FF,FF,FF,FF, then switch to run mode with i_pc = 0,4,8 at fetch_en = 1.
  - o_words_loaded = 3 and o_load_done = 1 after the 12th byte.
  - Outputs are 8C010004, 00000000, FFFFFFFF on consecutive cycles, with o_halt = 1 only on the third.
- After load done, send byte 0x12 -> o_load_error = 1, o_words_loaded unchanged, and word 0 still 8C010004.
- Run mode, i_pc = 4 then i_fetch_en = 0 for 3 cycles while i_pc changes to 8 -> o_instruction stays at word 1 for 3 cycles.
- Assert i_flush together with i_fetch_en at i_pc = 0 -> o_instruction = 0 next cycle; the following fetch returns 8C010004.
- NWORDS = 4, load 4 non-HALT words -> o_load_done = 1 after the 16th byte. Then i_pc = 0x10 -> reads word 0 (wrap).
- Load 2 bytes, drop i_load_en for 5 cycles, then send 2 more bytes -> one word written, with value {b0,b1,b2,b3}.
- Assert i_rst mid-word -> counters and outputs reset; the next 4 bytes write word 0.
